// File: rtl/uart_tx_queue.sv
// Byte FIFO plus send sequencer feeding a reset-less UART transmitter.
// One byte is in flight at a time; the next is released on tx_done or after a timeout.
module uart_tx_queue #(
  parameter int DEPTH         = 16,
  parameter int TICKS_PER_BIT = 104,
  parameter int TIMEOUT       = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     busy,
  output logic                     timeout,
  output logic [1:0]               dbg_state
);

  localparam int AW          = $clog2(DEPTH);
  localparam int INIT_CYCLES = 11 * TICKS_PER_BIT;
  localparam int INIT_W      = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Write port: a transfer happens on wr_valid && wr_ready. wr_ready may be high
  // while full only in the cycle the head is popped, so push and pop pair up.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                timeout_q, timeout_d;
  logic                ready_en_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [7:0]          mem_q [DEPTH];

  logic                full;
  logic                is_empty;
  logic                pop;
  logic                push;
  logic                set_timeout;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign is_empty = (count_q == '0);
  assign pop      = (state_q == ST_IDLE) && !is_empty && !flush;
  assign wr_ready = ready_en_q && (!full || pop);
  assign push     = wr_valid && wr_ready && !flush;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    tx_data_d   = tx_data_q;
    set_timeout = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Let any frame started before reset run out; tx_done is meaningless here.
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    if (set_timeout) timeout_d = 1'b1;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      timeout_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      timeout_q  <= 1'b0;
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
      ready_en_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign tx_data   = tx_data_q;
  assign tx_send   = (state_q == ST_SEND);
  assign count     = count_q;
  assign empty     = is_empty;
  assign busy      = (state_q != ST_IDLE);
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed steps plus a random phase, with a queue-based
// reference model watching every cycle.
module tb_uart_tx_queue;
  localparam int DEPTH    = 16;
  localparam int TPB      = 104;
  localparam int TIMEOUT  = 2048;
  localparam int INIT_CYC = 11 * TPB;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   flush;
  logic [7:0]             tx_data;
  logic                   tx_send;
  logic                   tx_done;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   busy;
  logic                   timeout;
  logic [1:0]             dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       m_in_flight;
  logic [7:0] m_last;
  logic       m_timeout;
  int         m_init_left;
  int         m_wait;
  logic       m_full_accept;

  uart_tx_queue #(.DEPTH(DEPTH), .TICKS_PER_BIT(TPB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .flush(flush), .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done),
    .count(count), .empty(empty), .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes queue in write order, leave on tx_send, one in flight.
  always @(negedge clk) begin
    logic sent;
    sent = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_in_flight   = 1'b0;
      m_last        = 8'h00;
      m_timeout     = 1'b0;
      m_init_left   = INIT_CYC;
      m_wait        = 0;
      m_full_accept = 1'b0;
    end else begin
      if (tx_send === 1'b1) begin
        chk("send_legal", 32'(!m_in_flight && exp_q.size() > 0 && m_init_left == 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("send_data", 32'(tx_data), 32'(exp_q[0]));
          m_last = exp_q.pop_front();
        end
        m_in_flight = 1'b1;
        m_wait      = 0;
        sent        = 1'b1;
      end else begin
        chk("data_hold", 32'(tx_data), 32'(m_last));
      end
      if (m_full_accept) chk("full_pop", 32'(tx_send), 32'd1);
      m_full_accept = 1'b0;
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("busy", 32'(busy), 32'(m_init_left > 0 || m_in_flight));
      chk("timeout", 32'(timeout), 32'(m_timeout));
      if (m_init_left < INIT_CYC && exp_q.size() < DEPTH) chk("wr_ready", 32'(wr_ready), 32'd1);
      if (m_init_left > 0) m_init_left--;
      if (m_in_flight && !sent) begin
        m_wait++;
        if (tx_done) begin
          m_in_flight = 1'b0;
        end else if (m_wait == TIMEOUT) begin
          m_in_flight = 1'b0;
          m_timeout   = 1'b1;
        end
      end
      if (flush) begin
        exp_q.delete();
        m_timeout = 1'b0;
      end else if (wr_valid && wr_ready) begin
        if (exp_q.size() >= DEPTH) m_full_accept = 1'b1;
        exp_q.push_back(wr_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    int n;
    n = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    while (wr_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) chk("write_wait", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_send(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_send !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("send_seen", 32'(tx_send), 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    int n;
    int sends;
    logic [7:0] b0, b1, c2;
    rst = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; flush = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_timeout", 32'(timeout), 32'd0);
    step();
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < INIT_CYC + 20) begin
      n++;
      @(negedge clk);
    end
    chk("init_len", 32'(n), 32'(INIT_CYC));

    // Single byte: send two cycles after the write, data held until tx_done.
    step();
    wr_data = 8'hA5; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1", 32'(tx_send), 32'd0);
    step();
    @(negedge clk);
    chk("lat_send", 32'(tx_send), 32'd1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    chk("t1_empty", 32'(empty), 32'd1);
    step();
    @(negedge clk);
    chk("send_1cyc", 32'(tx_send), 32'd0);
    repeat ($urandom_range(3, 30)) step();
    @(negedge clk);
    chk("t1_hold", 32'(tx_data), 32'hA5);
    step();
    pulse_done();
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);

    // Burst with tx_done stalled until the queue fills.
    step();
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      if (i == 15) begin
        @(negedge clk);
        chk("burst_cnt15", 32'(count), 32'd15);
        step();
      end
    end
    @(negedge clk);
    chk("burst_full", 32'(count), 32'(DEPTH));
    chk("burst_ready0", 32'(wr_ready), 32'd0);

    // Full queue: write pairs with the pop, count stays at DEPTH.
    step();
    wr_data = 8'h11; wr_valid = 1'b1;
    @(negedge clk);
    chk("full_ready0", 32'(wr_ready), 32'd0);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    @(negedge clk);
    chk("full_ready1", 32'(wr_ready), 32'd1);
    chk("full_cnt_pop", 32'(count), 32'(DEPTH));
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("full_send", 32'(tx_send), 32'd1);
    chk("full_data", 32'(tx_data), 32'h01);
    chk("full_cnt", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 16; i++) begin
      step();
      repeat ($urandom_range(0, 6)) step();
      pulse_done();
      @(negedge clk);
      chk("gap_d1", 32'(tx_send), 32'd0);
      step();
      @(negedge clk);
      chk("gap_d2", 32'(tx_send), 32'd1);
      chk("order", 32'(tx_data), 32'(i + 2));
    end
    step();
    pulse_done();
    @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Timeout: no tx_done at all.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    step();
    write_byte(b0);
    write_byte(b1);
    wait_send(5);
    chk("to_data0", 32'(tx_data), 32'(b0));
    n = 0;
    while (timeout !== 1'b1 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TIMEOUT + 1));
    @(negedge clk);
    chk("to_next_send", 32'(tx_send), 32'd1);
    chk("to_data1", 32'(tx_data), 32'(b1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("to_flush_clr", 32'(timeout), 32'd0);
    step();
    pulse_done();

    // Flush during WAIT with five queued; a write in the flush cycle is dropped.
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    @(negedge clk);
    chk("fl_cnt5", 32'(count), 32'd5);
    b0 = tx_data;
    step();
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'($urandom);
    step();
    flush = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("fl_cnt0", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_busy", 32'(busy), 32'd1);
    step();
    pulse_done();
    sends = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_send === 1'b1) sends++;
    end
    chk("fl_no_send", 32'(sends), 32'd0);

    // Reset mid-WAIT; tx_done during INIT is ignored, a byte written in INIT goes out after.
    c2 = 8'($urandom);
    step();
    write_byte(8'($urandom));
    wait_send(5);
    step();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_data", 32'(tx_data), 32'h00);
    chk("rst2_ready", 32'(wr_ready), 32'd0);
    step();
    rst = 1'b0;
    sends = 0;
    for (int i = 1; i <= INIT_CYC; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) sends++;
      step();
      tx_done  = (i == 3 || i == 400 || i == 1000);
      wr_valid = (i == 10);
      wr_data  = c2;
    end
    chk("init_no_send", 32'(sends), 32'd0);
    @(negedge clk);
    chk("post_init_idle", 32'(tx_send), 32'd0);
    step();
    @(negedge clk);
    chk("post_init_send", 32'(tx_send), 32'd1);
    chk("post_init_data", 32'(tx_data), 32'(c2));
    step();
    pulse_done();

    // Random traffic against the model.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 4)) step();
          write_byte(8'($urandom));
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          wait_send(600);
          step();
          repeat ($urandom_range(0, 20)) step();
          pulse_done();
        end
      end
    join
    repeat (5) step();
    @(negedge clk);
    chk("end_empty", 32'(empty), 32'd1);
    chk("end_idle", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
